// File: rtl/mem_debug_reader.sv
// Walks the data memory's debug read port from word 0 to DEPTH-1 and streams each word LSB-first on a valid/ready byte link.
// Optional trailing XOR checksum byte is built when MEM_DEBUG_READER_CHECKSUM_EN is defined.
module mem_debug_reader #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 32,
  parameter int DEPTH   = 1024
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_data_debug,
  output logic [NB_ADDR-1:0] o_addr_debug,
  output logic [7:0]         o_byte,
  output logic               o_byte_valid,
  input  logic               i_byte_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam int NB_BYTES = NB_DATA / 8;
  localparam int BIDX_W   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam logic [BIDX_W-1:0]  LAST_IDX  = BIDX_W'(NB_BYTES - 1);
  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(DEPTH - 1);

`ifdef MEM_DEBUG_READER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_SEND  = 3'd2,
    S_CSUM  = 3'd3,
    S_DONE  = 3'd4
  } state_t;
  logic [7:0] csum_q, csum_d;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_SEND  = 3'd2,
    S_DONE  = 3'd4
  } state_t;
`endif

  // Handshake: a byte moves on any cycle where o_byte_valid and i_byte_ready
  // are both high; valid and byte are held until then and never look at ready.
  state_t             state_q, state_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic [NB_DATA-1:0] word_q, word_d;
  logic [BIDX_W-1:0]  idx_q, idx_d;
  logic [7:0]         cur_byte;
  logic [7:0]         byte_out;
  logic               byte_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      idx_q   <= '0;
`ifdef MEM_DEBUG_READER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
`ifdef MEM_DEBUG_READER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < NB_BYTES; i++) begin
      if (idx_q == BIDX_W'(i)) cur_byte = word_q[i*8 +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_d     = word_q;
    idx_d      = idx_q;
    byte_valid = 1'b0;
    byte_out   = '0;
`ifdef MEM_DEBUG_READER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef MEM_DEBUG_READER_CHECKSUM_EN
        csum_d = '0;
`endif
        if (i_start) begin
          addr_d  = '0;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        // Memory read is combinational on the address registered last edge.
        word_d  = i_data_debug;
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        byte_valid = 1'b1;
        byte_out   = cur_byte;
        if (i_byte_ready) begin
`ifdef MEM_DEBUG_READER_CHECKSUM_EN
          csum_d = csum_q ^ cur_byte;
`endif
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + BIDX_W'(1);
          end else if (addr_q != LAST_ADDR) begin
            addr_d  = addr_q + NB_ADDR'(1);
            state_d = S_LATCH;
          end else begin
`ifdef MEM_DEBUG_READER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef MEM_DEBUG_READER_CHECKSUM_EN
      S_CSUM: begin
        byte_valid = 1'b1;
        byte_out   = csum_q;
        if (i_byte_ready) state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign o_addr_debug = addr_q;
  assign o_byte       = byte_out;
  assign o_byte_valid = byte_valid;
  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_debug_reader.sv
// Scoreboard bench for mem_debug_reader (DEPTH=2, 32-bit words); honours MEM_DEBUG_READER_CHECKSUM_EN.
module tb_mem_debug_reader;

  localparam int NB_DATA  = 32;
  localparam int NB_ADDR  = 32;
  localparam int DEPTH    = 2;
  localparam int NB_BYTES = NB_DATA / 8;
`ifdef MEM_DEBUG_READER_CHECKSUM_EN
  localparam int BASE = DEPTH * (NB_BYTES + 1) + 1;
`else
  localparam int BASE = DEPTH * (NB_BYTES + 1);
`endif

  logic               clk = 1'b0;
  logic               i_rst, i_start, i_byte_ready;
  logic [NB_DATA-1:0] i_data_debug;
  logic [NB_ADDR-1:0] o_addr_debug;
  logic [7:0]         o_byte;
  logic               o_byte_valid, o_busy, o_done;

  logic [NB_DATA-1:0] mem [DEPTH];
  logic [15:0]        exp_q[$];
  int                 checks = 0;
  int                 errors = 0;
  int                 cyc = 0;
  int                 start_c = 0;
  int                 stall_cnt = 0;
  int                 done_cnt = 0;
  bit                 rnd_ready = 1'b0;

  mem_debug_reader #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_data_debug (i_data_debug),
    .o_addr_debug (o_addr_debug),
    .o_byte       (o_byte),
    .o_byte_valid (o_byte_valid),
    .i_byte_ready (i_byte_ready),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  // clock / reset-independent memory model
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign i_data_debug = (o_addr_debug == 0) ? mem[0] :
                        (o_addr_debug == 1) ? mem[1] : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // scoreboard: every presented byte is compared with the queue head
  always @(negedge clk) begin
    if (!i_rst) begin
      if (o_byte_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'd1, 32'd0);
        end else begin
          check("byte", {24'd0, o_byte}, {24'd0, exp_q[0][7:0]});
          check("addr", o_addr_debug, {24'd0, exp_q[0][15:8]});
          if (i_byte_ready) void'(exp_q.pop_front());
          else stall_cnt++;
        end
      end
      if (o_done) begin
        done_cnt++;
        check("done_cycle", cyc, start_c + BASE + stall_cnt);
      end
    end
  end

  task automatic start_dump();
    logic [7:0] cs = 8'h00;
    logic [7:0] b;
    for (int w = 0; w < DEPTH; w++) begin
      for (int k = 0; k < NB_BYTES; k++) begin
        b = mem[w][k*8 +: 8];
        cs = cs ^ b;
        exp_q.push_back({8'(w), b});
      end
    end
`ifdef MEM_DEBUG_READER_CHECKSUM_EN
    exp_q.push_back({8'(DEPTH - 1), cs});
`endif
    stall_cnt = 0;
    done_cnt  = 0;
    @(posedge clk); #1;
    i_start = 1'b1;
    @(posedge clk); #1;
    start_c = cyc;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (done_cnt == 0 && n < max_cyc) begin
      @(posedge clk); #1;
      if (rnd_ready) i_byte_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
    i_byte_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("done_count", done_cnt, 32'd1);
    check("queue_empty", exp_q.size(), 32'd0);
    check("idle_busy", {31'd0, o_busy}, 32'd0);
  endtask

  task automatic wait_byte(input logic [7:0] val, output bit found);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(posedge clk); #1;
      if (o_byte_valid && o_byte == val) found = 1'b1;
    end
    if (!found) check("wait_byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_addr"},  o_addr_debug, 32'd0);
    check({tag, "_byte"},  {24'd0, o_byte}, 32'd0);
    check({tag, "_valid"}, {31'd0, o_byte_valid}, 32'd0);
    check({tag, "_busy"},  {31'd0, o_busy}, 32'd0);
    check({tag, "_done"},  {31'd0, o_done}, 32'd0);
  endtask

  initial begin
    bit found;
    mem[0] = 32'h1122_3344;
    mem[1] = 32'hAABB_CCDD;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_byte_ready = 1'b1;

    // reset with random inputs
    repeat (2) begin
      i_start      = 1'($urandom_range(0, 1));
      i_byte_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_outputs_zero("reset");
    end
    i_rst = 1'b0;
    i_start = 1'b0;
    i_byte_ready = 1'b1;
    @(posedge clk); #1;
    check("start_in_reset_ignored", {31'd0, o_busy}, 32'd0);

    // basic dump
    start_dump();
    check("latch_busy", {31'd0, o_busy}, 32'd1);
    check("latch_valid", {31'd0, o_byte_valid}, 32'd0);
    wait_done(100);

    // backpressure on byte 0x22
    start_dump();
    wait_byte(8'h22, found);
    i_byte_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_byte_ready = 1'b1;
    wait_done(100);
    check("stall_count", stall_cnt, 32'd3);

    // start while busy
    start_dump();
    repeat (4) @(posedge clk);
    #1;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    wait_done(100);

    // reset mid-dump during 0xCC, then restart from word 0
    start_dump();
    wait_byte(8'hCC, found);
    i_rst = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("mid_reset");
    i_rst = 1'b0;
    exp_q.delete();
    start_dump();
    wait_done(100);

    // random data with random ready
    for (int t = 0; t < 3; t++) begin
      mem[0] = $urandom;
      mem[1] = $urandom;
      rnd_ready = 1'b1;
      start_dump();
      wait_done(400);
      rnd_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
